duck_sprite_addr_gen: RTL and testbench
=======================================

# duck_sprite_addr_gen

Pixel-address requester for the duck sprite sheet ROM. Each cycle it takes the VGA scan position and the duck's screen position, then issues a 13-bit sprite-sheet address to the duck sprite generator. It reads the returned 6-bit colour and asserts a draw enable aligned to that colour, with the magenta key treated as transparent. It also owns the duck animation state machine (fly flap, hit freeze, fall, gone) and sits between the game logic and the pixel mux of the display path.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines; frame tick fires at hcount==0, vcount==V_ACTIVE
- ANIM_DIV, 8, frame ticks per flap frame toggle
- HIT_FRAMES, 30, frame ticks the hit pose is held
- FALL_STEP, 4, lines the duck drops per frame tick while falling
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- hcount  in  10  current scan column
- vcount  in  10  current scan row
- duck_x  in  10  sprite left edge, sampled on frame tick
- duck_y  in  10  sprite top edge, sampled on frame tick
- hit  in  1  single-cycle pulse: duck shot
- respawn  in  1  single-cycle pulse: return to flying
- dir_left  in  1  facing left (used only with DUCK_HFLIP_EN)
- rgb  in  6  colour returned by the sprite generator
- addr  out  13  sprite-sheet address to the sprite generator
- draw_en  out  1  current rgb is an opaque duck pixel
- duck_state  out  2  FLY=0, HIT=1, FALL=2, GONE=3

## Operation
- Sheet is 150×50 with three 50×50 frames side by side: frame 0 wings up, frame 1 wings down, frame 2 shot.
- Frame tick: latch duck_x into pos_x and duck_y into pos_y, except in FALL, where pos_y += FALL_STEP and duck_y is ignored.
- in_box = (hcount − pos_x) < 50 and (vcount − pos_y) < 50, using unsigned 10-bit differences, so scan positions left of or above the box fail.
- col = hcount − pos_x; row = vcount − pos_y, or 49 − row in FALL (vertical flip).
- addr = row*150 + frame*50 + col. Maximum value is 7499. When in_box=0, addr is driven to 0.
- FSM:
  - FLY: flap counter counts frame ticks; every ANIM_DIV ticks the frame toggles 0↔1. hit → HIT.
  - HIT: frame 2; hold counter loads HIT_FRAMES and decrements per tick; at 0 → FALL.
  - FALL: frame 2, flipped. When pos_y ≥ V_ACTIVE after a step → GONE.
  - GONE: in_box forced 0; respawn → FLY with frame 0 and counters cleared.
- hit is ignored outside FLY. respawn is ignored outside GONE. hit and respawn together: hit wins in FLY, respawn wins in GONE.
- draw_en = in_box delayed by 2 cycles AND rgb ≠ 6'b110011 (magenta key).
- State changes take effect only on frame ticks (hit/respawn are registered and applied at the next tick), so a frame never renders with mixed poses.

## Timing
- Cycle t: hcount/vcount presented. t+1: addr registered. t+2: rgb valid from the sprite generator's ROM register, and draw_en asserted combinationally from the 2-stage in_box pipe.
- Pixel latency is therefore 2 clocks. The downstream mux must delay its background path by 2.
- Reset values: addr=0, draw_en=0, duck_state=FLY, frame=0, pos_x=pos_y=0, all counters 0, in_box pipe cleared.
- Reset mid-frame clears the pipe immediately; draw_en stays 0 until at least 2 cycles after release.
- pos_y saturates at 1023 during FALL; it does not wrap.

## Configuration
- DUCK_HFLIP_EN defined: when dir_left=1, col = 49 − col in all states, mirroring the duck horizontally.
- DUCK_HFLIP_EN undefined: dir_left is unused and the duck always faces right.

## Structure
- The shared package duck_pkg holds:
  - SPRITE_W=50, SPRITE_H=50, SHEET_W=150
  - TRANSPARENT_RGB=6'b110011
  - the duck_state_t enum (FLY, HIT, FALL, GONE)
  - the frame-index constants
- One sub-module, duck_anim_fsm, contains the state register, flap counter, hold counter, and fall position update. It outputs the state, frame index, flip flags and pos_y.
- The top level does the box test, address arithmetic and 2-stage alignment.

## Test plan
- Duck at (100,200) in FLY frame 0; scan (100,200) → addr=0 at t+1; draw_en=1 at t+2 when rgb=6'b000000. Scan (149,249) → addr=7399.
- Scan (99,200) and (150,200) → in_box=0, addr=0, draw_en=0. rgb=6'b110011 inside the box → draw_en=0.
- FLY with ANIM_DIV=8 → frame toggles every 8 frame ticks. At (100,200), scan (110,205) gives addr 760 (frame 0) and 810 (frame 1).
- hit mid-frame → state HIT at the next tick; frame 2 held 30 ticks, then FALL. Row 0 of the box reads sheet row 49 (addr 7450+col), and pos_y increases by 4 per tick.
- FALL with pos_y 476 → after the next tick, GONE and draw_en=0 everywhere. respawn → FLY, frame 0. hit issued in GONE → no effect.
- Assert rst during FALL → duck_state=FLY, addr=0, draw_en=0 immediately. With DUCK_HFLIP_EN and dir_left=1, scan (100,200) → addr=49.

Source files
------------

// File: rtl/duck_pkg.sv
// Shared types and constants for the duck sprite address path.
// Optional horizontal mirror is enabled by the DUCK_HFLIP_EN macro.
package duck_pkg;
  localparam int SPRITE_W = 50;
  localparam int SPRITE_H = 50;
  localparam int SHEET_W = 150;
  localparam int CNT_W = 8;
  localparam logic [5:0] TRANSPARENT_RGB = 6'b110011;

  typedef enum logic [1:0] {
    FLY  = 2'd0,
    HIT  = 2'd1,
    FALL = 2'd2,
    GONE = 2'd3
  } duck_state_t;

  typedef logic [1:0] frame_t;

  localparam frame_t FRAME_UP = 2'd0;
  localparam frame_t FRAME_DOWN = 2'd1;
  localparam frame_t FRAME_SHOT = 2'd2;
endpackage

// File: rtl/duck_sprite_addr_gen_if.sv
// Scan position in, sheet address out, colour back, draw enable out.
// Used by duck_sprite_addr_gen (DUCK_HFLIP_EN has no effect here).
interface duck_sprite_addr_gen_if;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [12:0] addr;
  logic [5:0]  rgb;
  logic        draw_en;

  modport master (
    input  hcount, vcount, rgb,
    output addr, draw_en
  );

  modport slave (
    output hcount, vcount, rgb,
    input  addr, draw_en
  );
endinterface

// File: rtl/duck_anim_fsm.sv
// Duck animation FSM: flap, hit hold, fall and gone; owns pos_y.
// DUCK_HFLIP_EN routes dir_left to the horizontal flip flag.
module duck_anim_fsm
  import duck_pkg::*;
#(
  parameter int V_ACTIVE   = 480,
  parameter int ANIM_DIV   = 8,
  parameter int HIT_FRAMES = 30,
  parameter int FALL_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        hit,
  input  logic        respawn,
  input  logic        dir_left,
  input  logic [9:0]  duck_y,
  output duck_state_t state,
  output frame_t      frame,
  output logic        vflip,
  output logic        hflip,
  output logic [9:0]  pos_y
);
  duck_state_t      state_q, state_d;
  frame_t           frame_q, frame_d;
  logic [CNT_W-1:0] flap_q, flap_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [9:0]       pos_y_q, pos_y_d;
  logic             hit_p_q, hit_p_d;
  logic             rsp_p_q, rsp_p_d;
  logic [10:0]      fall_sum;
  logic [9:0]       fall_y;

  always_comb begin
    fall_sum = {1'b0, pos_y_q} + 11'(FALL_STEP);
    fall_y   = fall_sum[10] ? 10'h3ff : fall_sum[9:0];
    state_d  = state_q;
    frame_d  = frame_q;
    flap_d   = flap_q;
    hold_d   = hold_q;
    pos_y_d  = pos_y_q;
    hit_p_d  = hit_p_q | (hit && state_q == FLY);
    rsp_p_d  = rsp_p_q | (respawn && state_q == GONE);
    if (tick) begin
      pos_y_d = duck_y;
      unique case (state_q)
        FLY: begin
          if (hit_p_q) begin
            state_d = HIT;
            frame_d = FRAME_SHOT;
            hold_d  = CNT_W'(HIT_FRAMES);
            flap_d  = '0;
          end else if (flap_q == CNT_W'(ANIM_DIV - 1)) begin
            flap_d  = '0;
            frame_d = (frame_q == FRAME_UP) ? FRAME_DOWN : FRAME_UP;
          end else begin
            flap_d = flap_q + 1'b1;
          end
        end
        HIT: begin
          hold_d = hold_q - 1'b1;
          if (hold_q == CNT_W'(1)) state_d = FALL;
        end
        FALL: begin
          pos_y_d = fall_y;
          if (fall_y >= 10'(V_ACTIVE)) state_d = GONE;
        end
        GONE: begin
          if (rsp_p_q) begin
            state_d = FLY;
            frame_d = FRAME_UP;
            flap_d  = '0;
            hold_d  = '0;
          end
        end
        default: ;
      endcase
      // a pulse landing on the tick itself waits for the following tick
      hit_p_d = hit && state_d == FLY;
      rsp_p_d = respawn && state_d == GONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FLY;
      frame_q <= FRAME_UP;
      flap_q  <= '0;
      hold_q  <= '0;
      pos_y_q <= '0;
      hit_p_q <= 1'b0;
      rsp_p_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      flap_q  <= flap_d;
      hold_q  <= hold_d;
      pos_y_q <= pos_y_d;
      hit_p_q <= hit_p_d;
      rsp_p_q <= rsp_p_d;
    end
  end

  assign state = state_q;
  assign frame = frame_q;
  assign vflip = state_q == FALL;
  assign pos_y = pos_y_q;

`ifdef DUCK_HFLIP_EN
  assign hflip = dir_left;
`else
  logic unused_dir_left;
  assign unused_dir_left = dir_left;
  assign hflip = 1'b0;
`endif
endmodule

// File: rtl/duck_sprite_addr_gen.sv
// Duck sprite-sheet address generator with 2-clock draw alignment.
// DUCK_HFLIP_EN mirrors the sprite when dir_left is set.
module duck_sprite_addr_gen
  import duck_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ANIM_DIV   = 8,
  parameter int HIT_FRAMES = 30,
  parameter int FALL_STEP  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  duck_sprite_addr_gen_if.master         pix,
  input  logic [9:0]                     duck_x,
  input  logic [9:0]                     duck_y,
  input  logic                           hit,
  input  logic                           respawn,
  input  logic                           dir_left,
  output logic [1:0]                     duck_state
);
  duck_state_t state;
  frame_t      frame;
  logic        vflip, hflip, tick;
  logic [9:0]  pos_y, dx, dy;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [12:0] addr_q, addr_d;
  logic        box_q1, box_q2, in_box;
  logic [5:0]  col, row;

  assign tick = pix.hcount == 10'd0 && pix.vcount == 10'(V_ACTIVE);

  duck_anim_fsm #(
    .V_ACTIVE  (V_ACTIVE),
    .ANIM_DIV  (ANIM_DIV),
    .HIT_FRAMES(HIT_FRAMES),
    .FALL_STEP (FALL_STEP)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .hit     (hit),
    .respawn (respawn),
    .dir_left(dir_left),
    .duck_y  (duck_y),
    .state   (state),
    .frame   (frame),
    .vflip   (vflip),
    .hflip   (hflip),
    .pos_y   (pos_y)
  );

  always_comb begin
    pos_x_d = tick ? duck_x : pos_x_q;
    // unsigned wrap makes scan positions left of / above the box fail
    dx = pix.hcount - pos_x_q;
    dy = pix.vcount - pos_y;
    in_box = dx < 10'(SPRITE_W) && dy < 10'(SPRITE_H)
          && pix.hcount < 10'(H_ACTIVE) && state != GONE;
    col = hflip ? 6'(SPRITE_W - 1) - dx[5:0] : dx[5:0];
    row = vflip ? 6'(SPRITE_H - 1) - dy[5:0] : dy[5:0];
    addr_d = '0;
    if (in_box) begin
      addr_d = 13'(row) * 13'(SHEET_W) + 13'(frame) * 13'(SPRITE_W)
             + 13'(col);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x_q <= '0;
      addr_q  <= '0;
      box_q1  <= 1'b0;
      box_q2  <= 1'b0;
    end else begin
      pos_x_q <= pos_x_d;
      addr_q  <= addr_d;
      box_q1  <= in_box;
      box_q2  <= box_q1;
    end
  end

  assign pix.addr    = addr_q;
  assign pix.draw_en = box_q2 && (pix.rgb != TRANSPARENT_RGB);
  assign duck_state  = state;
endmodule

// File: tb/tb_duck_sprite_addr_gen.sv
// Directed bench for duck_sprite_addr_gen.
// Build with DUCK_HFLIP_EN to exercise the mirrored address.
module tb_duck_sprite_addr_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] duck_x = '0;
  logic [9:0] duck_y = '0;
  logic       hit = 1'b0;
  logic       respawn = 1'b0;
  logic       dir_left = 1'b0;
  logic [1:0] duck_state;
  int         checks = 0;
  int         errors = 0;

  duck_sprite_addr_gen_if pif ();

  duck_sprite_addr_gen dut (
    .clk       (clk),
    .rst       (rst),
    .pix       (pif),
    .duck_x    (duck_x),
    .duck_y    (duck_y),
    .hit       (hit),
    .respawn   (respawn),
    .dir_left  (dir_left),
    .duck_state(duck_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    pif.hcount = 10'd700;
    pif.vcount = 10'd600;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      pif.hcount = 10'd0;
      pif.vcount = 10'd480;
      cyc();
      park();
      cyc();
    end
  endtask

  task automatic scan(input string tag, input int h, input int v,
                      input logic [5:0] c, input int ea, input int ed);
    pif.hcount = 10'(h);
    pif.vcount = 10'(v);
    cyc();
    chk({tag, "_addr"}, int'(pif.addr), ea);
    park();
    cyc();
    pif.rgb = c;
    #1;
    chk({tag, "_draw"}, int'(pif.draw_en), ed);
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
  endtask

  task automatic pulse_rsp();
    respawn = 1'b1;
    cyc();
    respawn = 1'b0;
  endtask

  initial begin
    park();
    pif.rgb = 6'd0;
    repeat (2) cyc();
    chk("rst_addr", int'(pif.addr), 0);
    chk("rst_draw", int'(pif.draw_en), 0);
    chk("rst_state", int'(duck_state), 0);
    rst = 1'b1;
    duck_x = 10'd100;
    duck_y = 10'd200;
    tick(1);
    scan("tl", 100, 200, 6'd0, 0, 1);
    scan("br", 149, 249, 6'd0, 7399, 1);
    scan("left", 99, 200, 6'd0, 0, 0);
    scan("right", 150, 200, 6'd0, 0, 0);
    scan("key", 110, 205, 6'b110011, 760, 0);
    tick(6);
    scan("f0", 110, 205, 6'd0, 760, 1);
    tick(1);
    scan("f1", 110, 205, 6'd0, 810, 1);
    pulse_hit();
    chk("hit_wait", int'(duck_state), 0);
    tick(1);
    chk("hit_st", int'(duck_state), 1);
    scan("shot", 110, 205, 6'd0, 860, 1);
    tick(29);
    chk("hit_hold", int'(duck_state), 1);
    tick(1);
    chk("fall_st", int'(duck_state), 2);
    scan("vflip", 110, 200, 6'd0, 7460, 1);
    tick(1);
    scan("step_above", 110, 203, 6'd0, 0, 0);
    scan("step_top", 110, 204, 6'd0, 7460, 1);
    tick(68);
    chk("fall_476", int'(duck_state), 2);
    scan("y476", 110, 476, 6'd0, 7460, 1);
    tick(1);
    chk("gone_st", int'(duck_state), 3);
    tick(1);
    scan("gone", 110, 205, 6'd0, 0, 0);
    pulse_hit();
    tick(1);
    chk("gone_hit", int'(duck_state), 3);
    pulse_rsp();
    chk("rsp_wait", int'(duck_state), 3);
    tick(1);
    chk("rsp_st", int'(duck_state), 0);
    scan("rsp_f0", 110, 205, 6'd0, 760, 1);
    pulse_hit();
    tick(31);
    chk("fall2_st", int'(duck_state), 2);
    pif.hcount = 10'd110;
    pif.vcount = 10'd205;
    pif.rgb = 6'd0;
    cyc();
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_state", int'(duck_state), 0);
    chk("mrst_addr", int'(pif.addr), 0);
    chk("mrst_draw", int'(pif.draw_en), 0);
    pif.hcount = 10'd10;
    pif.vcount = 10'd10;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rel_draw1", int'(pif.draw_en), 0);
    chk("rel_addr", int'(pif.addr), 1510);
    cyc();
    chk("rel_draw2", int'(pif.draw_en), 1);
    park();
    dir_left = 1'b1;
    tick(1);
`ifdef DUCK_HFLIP_EN
    scan("hflip", 100, 200, 6'd0, 49, 1);
`else
    scan("noflip", 100, 200, 6'd0, 0, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
